rd_master: RTL and testbench

AXI4 full read master for the ADMA datapath, the read-direction counterpart of the write master. It accepts a single-burst read request (address, length) from the read buffer, issues it on the AXI AR channel, and forwards R-channel beats to the read buffer with backpressure. One burst is outstanding at a time; completion and error status are reported per burst.

---
 rtl/rd_master.sv | 162 ++++++++++++++++
 tb/tb_rd_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_master.sv
// rd_master: single-outstanding AXI4 read master for the ADMA read path.
// The read buffer posts one request (address, length). The master issues that
// burst on AR and forwards the R beats to the buffer, which can apply
// backpressure. It pulses axi_rd_done when the burst ends. axi_rd_err is a
// sticky error flag that is cleared when the next request is accepted.
//
// Optional build macro: RD_LEN_CHECK_EN
//   When defined, an 8-bit beat counter is compared with the granted length.
//   An early rlast, or a burst that runs past arlen without rlast, also sets
//   axi_rd_err.
//
// state   | meaning
// RD_IDLE | waiting for a request; axi_ar_ready high
// RD_ADDR | m_axi_arvalid held until the slave takes the address
// RD_DATA | R channel passed through to the read buffer
// RD_END  | one-cycle done pulse, then back to idle
module rd_master #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 128
) (
   input  logic                      axi_clk,
   input  logic                      reset,
   // request / data interface to rd_buffer
   input  logic                      axi_ar_req_en,
   output logic                      axi_ar_ready,
   input  logic [7:0]                axi_ar_burst_len,
   input  logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
   output logic                      axi_r_valid,
   input  logic                      axi_r_ready,
   output logic [AXI_DATA_WIDTH-1:0] axi_r_data,
   output logic                      axi_r_last,
   output logic                      axi_rd_done,
   output logic                      axi_rd_err,
   // AXI4 AR channel
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [3:0]                m_axi_arid,
   output logic [7:0]                m_axi_arlen,
   output logic [1:0]                m_axi_arburst,
   output logic [2:0]                m_axi_arsize,
   output logic [2:0]                m_axi_arprot,
   output logic [3:0]                m_axi_arqos,
   output logic                      m_axi_arlock,
   output logic [3:0]                m_axi_arcache,
   // AXI4 R channel
   input  logic [3:0]                m_axi_rid,
   input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rlast,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready
);

   localparam logic [2:0] AR_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

   typedef enum logic [3:0] {
      RD_IDLE = 4'b0001,
      RD_ADDR = 4'b0010,
      RD_DATA = 4'b0100,
      RD_END  = 4'b1000
   } rd_state_t;

   rd_state_t state;
   logic      in_data;
   logic      r_hs;

`ifdef RD_LEN_CHECK_EN
   logic [7:0] beat_cnt;
`endif

   // The slave ID and the low response bit do not change the master's behaviour.
   logic unused_in;
   assign unused_in = ^{m_axi_rid, m_axi_rresp[0]};

   // Constant AR attributes: ID 0, INCR bursts, full-width beats.
   assign m_axi_arid    = 4'd0;
   assign m_axi_arburst = 2'b01;
   assign m_axi_arsize  = AR_SIZE;
   assign m_axi_arprot  = 3'd0;
   assign m_axi_arqos   = 4'd0;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'd0;

   // The R channel passes straight through. Both valid and ready are gated by
   // the data state, so no beat is taken outside the granted burst.
   assign in_data      = (state == RD_DATA);
   assign axi_ar_ready = (state == RD_IDLE);
   assign m_axi_rready = axi_r_ready && in_data;
   assign axi_r_valid  = m_axi_rvalid && in_data;
   assign axi_r_data   = m_axi_rdata;
   assign axi_r_last   = m_axi_rlast;
   assign r_hs         = m_axi_rvalid && m_axi_rready;

   // Burst sequencer with registered AR outputs, done pulse and sticky error.
   always_ff @(posedge axi_clk or posedge reset) begin
      if (reset) begin
         state         <= RD_IDLE;
         m_axi_arvalid <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arlen   <= 8'd0;
         axi_rd_done   <= 1'b0;
         axi_rd_err    <= 1'b0;
`ifdef RD_LEN_CHECK_EN
         beat_cnt      <= 8'd0;
`endif
      end else begin
         case (state)
            RD_IDLE: begin
               axi_rd_done <= 1'b0;
               if (axi_ar_req_en) begin
                  m_axi_araddr  <= axi_ar_addr;
                  m_axi_arlen   <= axi_ar_burst_len;
                  m_axi_arvalid <= 1'b1;
                  axi_rd_err    <= 1'b0;
`ifdef RD_LEN_CHECK_EN
                  beat_cnt      <= 8'd0;
`endif
                  state         <= RD_ADDR;
               end
            end
            RD_ADDR: begin
               if (m_axi_arvalid && m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  state         <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (r_hs) begin
                  if (m_axi_rresp[1]) begin
                     axi_rd_err <= 1'b1;
                  end
`ifdef RD_LEN_CHECK_EN
                  // An early rlast is flagged, and so is the beat that should
                  // have carried rlast but did not. Beats after that one are
                  // still accepted until the slave asserts rlast.
                  if (m_axi_rlast ? (beat_cnt != m_axi_arlen)
                                  : (beat_cnt == m_axi_arlen)) begin
                     axi_rd_err <= 1'b1;
                  end
                  beat_cnt <= beat_cnt + 8'd1;
`endif
                  if (m_axi_rlast) begin
                     axi_rd_done <= 1'b1;
                     state       <= RD_END;
                  end
               end
            end
            RD_END: begin
               axi_rd_done <= 1'b0;
               state       <= RD_IDLE;
            end
            default: begin
               m_axi_arvalid <= 1'b0;
               axi_rd_done   <= 1'b0;
               state         <= RD_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rd_master.sv
// tb_rd_master: randomized bench for rd_master with a burst-level reference model.
// The model predicts the forwarded beat stream, the done timing and the error
// flag from the slave's responses. When RD_LEN_CHECK_EN is defined it also
// predicts length-mismatch errors.
module tb_rd_master;

   localparam int AW = 32;
   localparam int DW = 128;

   logic          axi_clk;
   logic          reset;
   logic          axi_ar_req_en;
   logic          axi_ar_ready;
   logic [7:0]    axi_ar_burst_len;
   logic [AW-1:0] axi_ar_addr;
   logic          axi_r_valid;
   logic          axi_r_ready;
   logic [DW-1:0] axi_r_data;
   logic          axi_r_last;
   logic          axi_rd_done;
   logic          axi_rd_err;
   logic          m_axi_arvalid;
   logic          m_axi_arready;
   logic [AW-1:0] m_axi_araddr;
   logic [3:0]    m_axi_arid;
   logic [7:0]    m_axi_arlen;
   logic [1:0]    m_axi_arburst;
   logic [2:0]    m_axi_arsize;
   logic [2:0]    m_axi_arprot;
   logic [3:0]    m_axi_arqos;
   logic          m_axi_arlock;
   logic [3:0]    m_axi_arcache;
   logic [3:0]    m_axi_rid;
   logic [DW-1:0] m_axi_rdata;
   logic [1:0]    m_axi_rresp;
   logic          m_axi_rlast;
   logic          m_axi_rvalid;
   logic          m_axi_rready;

   int vectors;
   int miscompares;

   rd_master #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
      .axi_clk          (axi_clk),
      .reset            (reset),
      .axi_ar_req_en    (axi_ar_req_en),
      .axi_ar_ready     (axi_ar_ready),
      .axi_ar_burst_len (axi_ar_burst_len),
      .axi_ar_addr      (axi_ar_addr),
      .axi_r_valid      (axi_r_valid),
      .axi_r_ready      (axi_r_ready),
      .axi_r_data       (axi_r_data),
      .axi_r_last       (axi_r_last),
      .axi_rd_done      (axi_rd_done),
      .axi_rd_err       (axi_rd_err),
      .m_axi_arvalid    (m_axi_arvalid),
      .m_axi_arready    (m_axi_arready),
      .m_axi_araddr     (m_axi_araddr),
      .m_axi_arid       (m_axi_arid),
      .m_axi_arlen      (m_axi_arlen),
      .m_axi_arburst    (m_axi_arburst),
      .m_axi_arsize     (m_axi_arsize),
      .m_axi_arprot     (m_axi_arprot),
      .m_axi_arqos      (m_axi_arqos),
      .m_axi_arlock     (m_axi_arlock),
      .m_axi_arcache    (m_axi_arcache),
      .m_axi_rid        (m_axi_rid),
      .m_axi_rdata      (m_axi_rdata),
      .m_axi_rresp      (m_axi_rresp),
      .m_axi_rlast      (m_axi_rlast),
      .m_axi_rvalid     (m_axi_rvalid),
      .m_axi_rready     (m_axi_rready)
   );

   initial axi_clk = 1'b0;
   always #5 axi_clk = ~axi_clk;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // rdy_mode: 0 always ready, 1 toggling, 2 random.
   // err_beat: -1 never an error response, -2 random responses, otherwise
   //           SLVERR on that beat index.
   task automatic run_burst(input logic [AW-1:0] addr, input int len, input int nbeats,
                            input int ar_wait, input int rdy_mode, input int err_beat);
      logic [DW-1:0] dat  [$];
      logic [1:0]    resp [$];
      logic [DW-1:0] exp_q [$];
      logic          err_model;
      int            b;
      int            fwd;
      int            guard;
      for (int i = 0; i < nbeats; i++) begin
         dat.push_back(rand_data());
         if (err_beat == -2)
            resp.push_back(($urandom_range(0, 7) == 0) ? 2'(2 + $urandom_range(0, 1))
                                                       : 2'($urandom_range(0, 1)));
         else if (i == err_beat)
            resp.push_back(2'b10);
         else
            resp.push_back(2'b00);
         exp_q.push_back(dat[i]);
      end

      // request handshake
      @(negedge axi_clk);
      chk("ar_ready_idle", axi_ar_ready, 1);
      axi_ar_addr      = addr;
      axi_ar_burst_len = 8'(len);
      axi_ar_req_en    = 1'b1;
      @(negedge axi_clk);
      axi_ar_req_en    = 1'b0;
      axi_ar_addr      = rand_data()[AW-1:0];
      axi_ar_burst_len = 8'($urandom);
      chk("arvalid_t1", m_axi_arvalid, 1);
      chk("araddr", m_axi_araddr, addr);
      chk("arlen", m_axi_arlen, 8'(len));
      chk("err_cleared", axi_rd_err, 0);
      chk("ar_ready_busy", axi_ar_ready, 0);

      // address phase: the R channel must stay closed
      m_axi_arready = 1'b0;
      for (int w = 0; w <= ar_wait; w++) begin
         if (w == ar_wait) m_axi_arready = 1'b1;
         axi_r_ready  = 1'b1;
         m_axi_rvalid = 1'($urandom_range(0, 1));
         m_axi_rlast  = 1'b0;
         #1;
         chk("rready_addr", m_axi_rready, 0);
         chk("rvalid_addr", axi_r_valid, 0);
         chk("arvalid_hold", m_axi_arvalid, 1);
         chk("araddr_hold", m_axi_araddr, addr);
         @(negedge axi_clk);
      end
      m_axi_arready = 1'b0;
      chk("arvalid_clr", m_axi_arvalid, 0);

      // data phase
      err_model = 1'b0;
      b = 0;
      fwd = 0;
      guard = 0;
      while (b < nbeats && guard < 500) begin
         chk("err_running", axi_rd_err, err_model);
         chk("done_early", axi_rd_done, 0);
         case (rdy_mode)
            0:       axi_r_ready = 1'b1;
            1:       axi_r_ready = guard[0];
            default: axi_r_ready = 1'($urandom_range(0, 1));
         endcase
         m_axi_rvalid = ($urandom_range(0, 3) != 0);
         m_axi_rdata  = dat[b];
         m_axi_rresp  = resp[b];
         m_axi_rlast  = (b == nbeats - 1);
         #1;
         chk("rready_pass", m_axi_rready, axi_r_ready);
         chk("rvalid_pass", axi_r_valid, m_axi_rvalid);
         if (axi_r_valid && axi_r_ready) begin
            fwd++;
            if (exp_q.size() > 0) chk("rdata", axi_r_data, exp_q.pop_front());
            chk("rlast", axi_r_last, (fwd == nbeats));
         end
         if (m_axi_rvalid && m_axi_rready) begin
            if (resp[b][1]) err_model = 1'b1;
`ifdef RD_LEN_CHECK_EN
            if (b == nbeats - 1 && b != len) err_model = 1'b1;
            if (b != nbeats - 1 && b == len) err_model = 1'b1;
`endif
            b++;
         end
         @(negedge axi_clk);
         guard++;
      end
      if (guard >= 500) chk("beat_timeout", 0, 1);
      chk("beats_fwd", fwd, nbeats);

      // completion: done at L+1, idle again at L+2
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      axi_r_ready  = 1'b1;
      #1;
      chk("done_pulse", axi_rd_done, 1);
      chk("err_final", axi_rd_err, err_model);
      chk("rready_end", m_axi_rready, 0);
      chk("ar_ready_end", axi_ar_ready, 0);
      @(negedge axi_clk);
      chk("done_one_cycle", axi_rd_done, 0);
      chk("ar_ready_back", axi_ar_ready, 1);
      chk("err_sticky", axi_rd_err, err_model);
   endtask

   initial begin
      int len;
      int nb;
      vectors          = 0;
      miscompares      = 0;
      reset            = 1'b1;
      axi_ar_req_en    = 1'b0;
      axi_ar_burst_len = 8'd0;
      axi_ar_addr      = '0;
      axi_r_ready      = 1'b0;
      m_axi_arready    = 1'b0;
      m_axi_rid        = 4'd0;
      m_axi_rdata      = '0;
      m_axi_rresp      = 2'b00;
      m_axi_rlast      = 1'b0;
      m_axi_rvalid     = 1'b0;
      repeat (2) @(negedge axi_clk);
      reset = 1'b0;
      axi_r_ready = 1'b1;
      #1;
      chk("rst_arvalid", m_axi_arvalid, 0);
      chk("rst_done", axi_rd_done, 0);
      chk("rst_err", axi_rd_err, 0);
      chk("rst_araddr", m_axi_araddr, 0);
      chk("rst_arlen", m_axi_arlen, 0);
      chk("rst_ar_ready", axi_ar_ready, 1);
      chk("rst_rready", m_axi_rready, 0);
      chk("arid", m_axi_arid, 0);
      chk("arburst", m_axi_arburst, 1);
      chk("arsize", m_axi_arsize, 4);
      chk("ar_misc", {m_axi_arprot, m_axi_arqos, m_axi_arlock, m_axi_arcache}, 0);

      // directed: plain 4-beat burst, toggling ready, error on beat 2
      run_burst(32'h1000, 3, 4, 2, 0, -1);
      run_burst(32'h1000, 3, 4, 2, 1, -1);
      run_burst(32'h2000, 3, 4, 0, 2, 1);
      // the next acceptance clears the error (checked inside run_burst)
      run_burst(32'h3000, 0, 1, 1, 0, -1);
      // early rlast: length error only when the check is built in
      run_burst(32'h4000, 7, 5, 1, 2, -1);
`ifdef RD_LEN_CHECK_EN
      run_burst(32'h5000, 2, 5, 0, 2, -1);
`endif

      // random bursts
      for (int k = 0; k < 25; k++) begin
         len = $urandom_range(0, 15);
         nb  = len + 1;
         run_burst(rand_data()[AW-1:0], len, nb, $urandom_range(0, 3),
                   $urandom_range(0, 2), -2);
      end

      // asynchronous reset while the address is pending
      @(negedge axi_clk);
      axi_ar_addr      = 32'h6000;
      axi_ar_burst_len = 8'd3;
      axi_ar_req_en    = 1'b1;
      @(negedge axi_clk);
      axi_ar_req_en = 1'b0;
      chk("rstmid_arvalid_pre", m_axi_arvalid, 1);
      #2;
      reset = 1'b1;
      axi_r_ready = 1'b1;
      #1;
      chk("rstmid_arvalid", m_axi_arvalid, 0);
      chk("rstmid_rready", m_axi_rready, 0);
      @(negedge axi_clk);
      reset = 1'b0;
      #1;
      chk("rstmid_ar_ready", axi_ar_ready, 1);
      chk("rstmid_araddr", m_axi_araddr, 0);
      run_burst(32'h7000, 2, 3, 0, 0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
